// File: rtl/iterative_shifter_pkg.sv
// Shared types for the iterative shift/rotate unit.
// Shift-type codes and FSM state encoding.
package iterative_shifter_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_AMT_W = 5;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/iterative_shifter_if.sv
// Request/response bundle between the control unit
// and the iterative shifter.
interface iterative_shifter_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
);

  logic             start;
  logic [WIDTH-1:0] operand;
  logic [AMT_W-1:0] shift_amount;
  logic [1:0]       shift_type;
  logic             carry_in;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             busy;
  logic             done;

  modport master (
    output start, operand, shift_amount,
    output shift_type, carry_in,
    input  result, carry_out, busy, done
  );

  modport slave (
    input  start, operand, shift_amount,
    input  shift_type, carry_in,
    output result, carry_out, busy, done
  );

endinterface

// File: rtl/iterative_shifter_shift_step.sv
// Single-position shift/rotate step: next value and
// the bit that falls out.
module shift_step
  import iterative_shifter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  shift_e           kind,
  output logic [WIDTH-1:0] next,
  output logic             bit_out
);

  always_comb begin
    next    = value;
    bit_out = 1'b0;
    unique case (kind)
      SH_LSL: begin
        next    = {value[WIDTH-2:0], 1'b0};
        bit_out = value[WIDTH-1];
      end
      SH_LSR: begin
        next    = {1'b0, value[WIDTH-1:1]};
        bit_out = value[0];
      end
      SH_ASR: begin
        next    = {value[WIDTH-1], value[WIDTH-1:1]};
        bit_out = value[0];
      end
      SH_ROR: begin
        next    = {value[0], value[WIDTH-1:1]};
        bit_out = value[0];
      end
      default: begin
        next    = value;
        bit_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// One-bit-per-clock shift/rotate unit producing the
// ALU B operand; start/busy/done handshake.
module iterative_shifter
  import iterative_shifter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) (
  input logic           clk,
  input logic           reset_n,
  iterative_shifter_if.slave bus
);

  state_e           state;
  shift_e           kind;
  logic [AMT_W-1:0] counter;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             busy;
  logic             done;

  logic [WIDTH-1:0] step_next;
  logic             step_out;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .value   (result),
    .kind    (kind),
    .next    (step_next),
    .bit_out (step_out)
  );

  // IDLE and DONE both accept a new request,
  // which gives back-to-back operation.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      kind      <= SH_LSL;
      counter   <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            result  <= bus.operand;
            kind    <= shift_e'(bus.shift_type);
            counter <= bus.shift_amount;
            if (bus.shift_amount == '0) begin
              carry_out <= bus.carry_in;
              state     <= ST_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              state <= ST_SHIFT;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          result    <= step_next;
          carry_out <= step_out;
          counter   <= counter - AMT_W'(1);
          if (counter == AMT_W'(1)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result    = result;
  assign bus.carry_out = carry_out;
  assign bus.busy      = busy;
  assign bus.done      = done;

endmodule

// File: tb/tb_iterative_shifter.sv
// Bench for iterative_shifter: vector table, random
// ops against an arithmetic model, handshake corners.
module tb_iterative_shifter;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  iterative_shifter_if #(.WIDTH(32), .AMT_W(5)) bus ();

  iterative_shifter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] op;
    int          amt;
    logic [1:0]  typ;
    logic        cin;
    logic [31:0] res;
    logic        co;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Reference: whole-operand arithmetic
  task automatic model(input logic [31:0] op,
                       input int n,
                       input logic [1:0] typ,
                       input logic cin,
                       output logic [31:0] res,
                       output logic co);
    if (n == 0) begin
      res = op;
      co  = cin;
    end else begin
      case (typ)
        2'b00: begin
          res = op << n;
          co  = op[W-n];
        end
        2'b01: begin
          res = op >> n;
          co  = op[n-1];
        end
        2'b10: begin
          res = 32'($signed(op) >>> n);
          co  = op[n-1];
        end
        default: begin
          res = (op >> n) | (op << (W - n));
          co  = op[n-1];
        end
      endcase
    end
  endtask

  // Issue one op; returns edges until done and busy count
  task automatic run_op(input logic [31:0] op,
                        input int n,
                        input logic [1:0] typ,
                        input logic cin,
                        output int edges,
                        output int busy_cnt);
    @(negedge clk);
    bus.start        = 1'b1;
    bus.operand      = op;
    bus.shift_amount = 5'(n);
    bus.shift_type   = typ;
    bus.carry_in     = cin;
    edges    = 0;
    busy_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (i == 0) begin
        bus.start        = 1'b0;
        bus.operand      = $urandom;
        bus.shift_amount = 5'($urandom);
        bus.shift_type   = 2'($urandom);
        bus.carry_in     = 1'($urandom);
      end
      if (bus.busy && bus.done)
        chk("busy_and_done", 1, 0);
      if (bus.done) break;
      if (bus.busy) busy_cnt++;
    end
    if (!bus.done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    logic [31:0] er;
    logic        ec;
    logic [31:0] held;
    int          edges;
    int          bc;
    int          n;
    logic [1:0]  t;
    logic [31:0] op;
    logic        cin;

    vecs[0] = '{32'h0000_0001, 4,  2'b00, 1'b0,
                32'h0000_0010, 1'b0};
    vecs[1] = '{32'h8000_0000, 31, 2'b10, 1'b0,
                32'hFFFF_FFFF, 1'b0};
    vecs[2] = '{32'h8000_0000, 31, 2'b01, 1'b0,
                32'h0000_0001, 1'b0};
    vecs[3] = '{32'h0000_0003, 1,  2'b01, 1'b0,
                32'h0000_0001, 1'b1};
    vecs[4] = '{32'h0000_0001, 1,  2'b11, 1'b0,
                32'h8000_0000, 1'b1};
    vecs[5] = '{32'h1234_5678, 8,  2'b11, 1'b1,
                32'h7812_3456, 1'b0};
    vecs[6] = '{32'hDEAD_BEEF, 0,  2'b10, 1'b1,
                32'hDEAD_BEEF, 1'b1};
    vecs[7] = '{32'h8000_0001, 1,  2'b00, 1'b0,
                32'h0000_0002, 1'b1};
    vecs[8] = '{32'h0000_0000, 0,  2'b01, 1'b0,
                32'h0000_0000, 1'b0};

    bus.start        = 1'b0;
    bus.operand      = '0;
    bus.shift_amount = '0;
    bus.shift_type   = '0;
    bus.carry_in     = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result", bus.result, 0);
    chk("rst_carry", 32'(bus.carry_out), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].amt, vecs[i].typ,
             vecs[i].cin, edges, bc);
      chk($sformatf("vec%0d_result", i),
          bus.result, vecs[i].res);
      chk($sformatf("vec%0d_carry", i),
          32'(bus.carry_out), 32'(vecs[i].co));
      chk($sformatf("vec%0d_latency", i),
          edges, vecs[i].amt + 1);
      chk($sformatf("vec%0d_busy", i),
          bc, vecs[i].amt);
    end

    // Results hold between operations
    held = bus.result;
    repeat (3) @(negedge clk);
    chk("hold_result", bus.result, held);
    chk("hold_done_low", 32'(bus.done), 0);

    for (int k = 0; k < 40; k++) begin
      op  = $urandom;
      n   = int'($urandom_range(0, 31));
      t   = 2'($urandom);
      cin = 1'($urandom);
      model(op, n, t, cin, er, ec);
      run_op(op, n, t, cin, edges, bc);
      chk($sformatf("rnd%0d_result", k), bus.result, er);
      chk($sformatf("rnd%0d_carry", k),
          32'(bus.carry_out), 32'(ec));
      chk($sformatf("rnd%0d_latency", k), edges, n + 1);
    end

    // Start during SHIFT is ignored; start in DONE accepted
    @(negedge clk);
    bus.start = 1'b1;
    bus.operand = 32'h1;
    bus.shift_amount = 5'd2;
    bus.shift_type = 2'b00;
    bus.carry_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.operand = 32'hFFFF_0000;
    bus.shift_amount = 5'd9;
    bus.shift_type = 2'b11;
    chk("b2b_busy", 32'(bus.busy), 1);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    edges = 0;
    while (!bus.done && edges < 40) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    chk("b2b_first_done", 32'(bus.done), 1);
    chk("b2b_ignored_result", bus.result, 32'h4);
    bus.start = 1'b1;
    bus.operand = 32'h10;
    bus.shift_amount = 5'd4;
    bus.shift_type = 2'b01;
    edges = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (i == 0) bus.start = 1'b0;
      if (bus.done) break;
    end
    chk("b2b_second_result", bus.result, 32'h1);
    chk("b2b_second_latency", edges, 5);

    // Reset in the middle of a long ASR
    @(negedge clk);
    bus.start = 1'b1;
    bus.operand = 32'hF000_0000;
    bus.shift_amount = 5'd20;
    bus.shift_type = 2'b10;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("mid_busy", 32'(bus.busy), 1);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_result", bus.result, 0);
    chk("mid_rst_carry", 32'(bus.carry_out), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    reset_n = 1'b1;
    bc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) bc++;
    end
    chk("mid_rst_no_done", bc, 0);
    model(32'hF000_0000, 20, 2'b10, 1'b0, er, ec);
    run_op(32'hF000_0000, 20, 2'b10, 1'b0, edges, bc);
    chk("post_rst_result", bus.result, er);
    chk("post_rst_carry", 32'(bus.carry_out), 32'(ec));
    chk("post_rst_latency", edges, 21);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
